// File: rtl/fc_mvm_par.sv
// fc_mvm_par: fully-connected layer y = f(W*x) with run-time loadable weights.
//
// An N-element signed input vector streams in over input_valid/input_ready.
// Rows are then computed P at a time (one row group), each lane doing a
// multiply-accumulate over the N columns. Each group's P results are then
// streamed out over output_valid/output_ready. Results saturate to T bits,
// and negative results can optionally be clamped to zero (RELU=1).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   input_valid   input_data carries an x element
//   input_ready   block accepts an x element (LOAD state only)
//   input_data    signed x element, x[0] first
//   output_valid  output_data carries a y element
//   output_ready  downstream accepts the y element
//   output_data   signed y element, y[0] first
//   w_wr_en       weight write strobe (honoured only while not busy)
//   w_addr        row-major weight address, W[i][j] at i*N+j
//   w_data        signed weight value
//   busy          high while a vector is being computed or drained
module fc_mvm_par #(
   parameter int M    = 6,
   parameter int N    = 6,
   parameter int T    = 16,
   parameter int P    = 2,
   parameter int RELU = 0,
   localparam int AW  = $clog2(M * N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          input_valid,
   output logic          input_ready,
   input  logic [T-1:0]  input_data,
   output logic          output_valid,
   input  logic          output_ready,
   output logic [T-1:0]  output_data,
   input  logic          w_wr_en,
   input  logic [AW-1:0] w_addr,
   input  logic [T-1:0]  w_data,
   output logic          busy
);

   localparam int AC = 2 * T + $clog2(N);                  // accumulator width
   localparam int G  = M / P;                              // number of row groups
   localparam int XW = $clog2(N);                          // x element index width
   localparam int CW = $clog2(N + 3);                      // compute-phase cycle counter width
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int LW = (P > 1) ? $clog2(P) : 1;

   localparam logic [1:0] S_LOAD  = 2'd0;
   localparam logic [1:0] S_COMP  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic signed [AC-1:0] SAT_MAX = {{(AC-T+1){1'b0}}, {(T-1){1'b1}}};
   localparam logic signed [AC-1:0] SAT_MIN = {{(AC-T+1){1'b1}}, {(T-1){1'b0}}};

   logic [1:0]              state_q, state_d;
   logic [XW-1:0]           cnt_q, cnt_d;
   logic [CW-1:0]           c_q, c_d;
   logic [GW-1:0]           g_q, g_d;
   logic [LW-1:0]           l_q, l_d;
   logic                    in_rdy_q, in_rdy_d;
   logic                    out_vld_q, out_vld_d;
   logic [T-1:0]            out_data_q, out_data_d;
   logic                    busy_q, busy_d;

   logic signed [T-1:0]     wmem_q [M*N];
   logic signed [T-1:0]     xmem_q [N];

   logic signed [T-1:0]     rd_w_q [P];
   logic signed [T-1:0]     rd_w_d [P];
   logic signed [T-1:0]     rd_x_q, rd_x_d;
   logic signed [2*T-1:0]   prod_q [P];
   logic signed [2*T-1:0]   prod_d [P];
   logic signed [AC-1:0]    acc_q  [P];
   logic signed [AC-1:0]    acc_d  [P];

   logic                    in_fire_s;
   logic                    out_fire_s;
   logic                    w_we_s;

   // Row-major weight address of row (g*P + p), column c.
   function automatic logic [AW-1:0] waddr_f(input logic [GW-1:0] g, input int p,
                                             input logic [CW-1:0] c);
      waddr_f = AW'((int'(g) * P + p) * N + int'(c));
   endfunction

   // Clamp the accumulator to the signed T-bit range, then optionally apply ReLU.
   function automatic logic [T-1:0] sat_f(input logic signed [AC-1:0] v);
      logic [T-1:0] r;
      if (v > SAT_MAX) begin
         r = {1'b0, {(T-1){1'b1}}};
      end else if (v < SAT_MIN) begin
         r = {1'b1, {(T-1){1'b0}}};
      end else begin
         r = v[T-1:0];
      end
      if ((RELU == 1) && r[T-1]) begin
         r = {T{1'b0}};
      end else begin
         r = r;
      end
      sat_f = r;
   endfunction

   assign in_fire_s  = input_valid & in_rdy_q;
   assign out_fire_s = out_vld_q & output_ready;
   assign w_we_s     = w_wr_en & ~busy_q & (int'(w_addr) < M * N);

   assign input_ready  = in_rdy_q;
   assign output_valid = out_vld_q;
   assign output_data  = out_data_q;
   assign busy         = busy_q;

   // Weight and x storage; deliberately not reset so weights survive a reset.
   always_ff @(posedge clk) begin
      if (w_we_s) begin
         wmem_q[w_addr] <= w_data;
      end
      if (in_fire_s) begin
         xmem_q[cnt_q] <= input_data;
      end
   end

   // MAC pipeline: cycle c reads column c, product of column c-2 is accumulated.
   always_comb begin
      rd_x_d = rd_x_q;
      rd_w_d = rd_w_q;
      acc_d  = acc_q;
      for (int p = 0; p < P; p++) begin
         prod_d[p] = (2*T)'(rd_w_q[p]) * (2*T)'(rd_x_q);
      end
      if ((state_q == S_COMP) && (int'(c_q) < N)) begin
         rd_x_d = xmem_q[c_q[XW-1:0]];
         for (int p = 0; p < P; p++) begin
            rd_w_d[p] = wmem_q[waddr_f(g_q, p, c_q)];
         end
      end else begin
         rd_x_d = rd_x_q;
      end
      if ((state_q == S_COMP) && (int'(c_q) >= 2) && (int'(c_q) <= N + 1)) begin
         for (int p = 0; p < P; p++) begin
            if (int'(c_q) == 2) begin
               acc_d[p] = AC'(prod_q[p]);
            end else begin
               acc_d[p] = acc_q[p] + AC'(prod_q[p]);
            end
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Control FSM: LOAD collects x, COMPUTE runs one row group, DRAIN emits its lanes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      c_d        = c_q;
      g_d        = g_q;
      l_d        = l_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      case (state_q)
         S_LOAD: begin
            if (in_fire_s) begin
               if (cnt_q == XW'(N - 1)) begin
                  cnt_d   = {XW{1'b0}};
                  c_d     = {CW{1'b0}};
                  g_d     = {GW{1'b0}};
                  state_d = S_COMP;
               end else begin
                  cnt_d = cnt_q + XW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_COMP: begin
            // The final accumulate lands at c = N+2, so lane 0 is registered out then.
            if (c_q == CW'(N + 2)) begin
               state_d    = S_DRAIN;
               l_d        = {LW{1'b0}};
               out_vld_d  = 1'b1;
               out_data_d = sat_f(acc_q[0]);
            end else begin
               c_d = c_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (out_fire_s) begin
               if (l_q == LW'(P - 1)) begin
                  out_vld_d = 1'b0;
                  c_d       = {CW{1'b0}};
                  if (g_q == GW'(G - 1)) begin
                     g_d     = {GW{1'b0}};
                     state_d = S_LOAD;
                  end else begin
                     g_d     = g_q + GW'(1);
                     state_d = S_COMP;
                  end
               end else begin
                  l_d        = l_q + LW'(1);
                  out_data_d = sat_f(acc_q[l_q + LW'(1)]);
               end
            end else begin
               l_d = l_q;
            end
         end
         default: begin
            state_d   = S_LOAD;
            out_vld_d = 1'b0;
         end
      endcase
      in_rdy_d = (state_d == S_LOAD);
      busy_d   = (state_d != S_LOAD);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_LOAD;
         cnt_q      <= {XW{1'b0}};
         c_q        <= {CW{1'b0}};
         g_q        <= {GW{1'b0}};
         l_q        <= {LW{1'b0}};
         in_rdy_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= {T{1'b0}};
         busy_q     <= 1'b0;
         rd_x_q     <= {T{1'b0}};
         for (int p = 0; p < P; p++) begin
            rd_w_q[p] <= {T{1'b0}};
            prod_q[p] <= {(2*T){1'b0}};
            acc_q[p]  <= {AC{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         c_q        <= c_d;
         g_q        <= g_d;
         l_q        <= l_d;
         in_rdy_q   <= in_rdy_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         busy_q     <= busy_d;
         rd_x_q     <= rd_x_d;
         for (int p = 0; p < P; p++) begin
            rd_w_q[p] <= rd_w_d[p];
            prod_q[p] <= prod_d[p];
            acc_q[p]  <= acc_d[p];
         end
      end
   end

endmodule

// File: tb/tb_fc_mvm_par.sv
// Testbench for fc_mvm_par (M=N=6, T=16, P=2). Two instances share all inputs:
// one with RELU=0 and one with RELU=1. A dot-product reference model with
// saturation predicts every y element; directed table records, hand-written
// corner sequences and randomized back-to-back vectors are checked against it.
module tb_fc_mvm_par;
   localparam int M = 6, N = 6, T = 16, P = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        input_valid, output_ready, w_wr_en;
   logic [15:0] input_data, w_data;
   logic [5:0]  w_addr;
   logic        ir0, ov0, busy0, ir1, ov1, busy1;
   logic [15:0] od0, od1;

   fc_mvm_par #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) dut0 (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir0),
      .input_data(input_data), .output_valid(ov0), .output_ready(output_ready),
      .output_data(od0), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .busy(busy0));

   fc_mvm_par #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) dut1 (
      .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(ir1),
      .input_data(input_data), .output_valid(ov1), .output_ready(output_ready),
      .output_data(od1), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .busy(busy1));

   always #5 clk = ~clk;

   int     tests = 0, fails = 0, cyc = 0;
   int     wm [M*N];
   int     xv [N];
   int     xcnt = 0;
   int     x_pend [$];
   longint exp0 [$], exp1 [$], obs0 [$], obs1 [$];
   int     in_gap = 0, out_gap = 0;
   int     hold_cnt = 0, hold_at = -1, out_seen = 0;
   bit     lat_en = 0, lat_armed = 0, prev_stall = 0, prev_valid = 0;
   int     acc_edge = 0;
   longint prev_data = 0;

   typedef struct {
      int wmode;
      int wval;
      int x  [N];
      int y0 [M];
      int y1 [M];
      bit hold;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic longint sd(input logic [15:0] v);
      return longint'($signed(v));
   endfunction

   // Reference: saturating dot product of model weights with the collected vector.
   function automatic longint ref_y(input int row, input bit relu);
      longint s = 0;
      for (int j = 0; j < N; j++) s += longint'(wm[row*N + j]) * longint'(xv[j]);
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return s;
   endfunction

   // One clock cycle: drive, check transfers and stability, advance past the edge.
   task automatic cycle();
      bit in_f, out_f;
      if (x_pend.size() > 0 && $urandom_range(99) >= in_gap) begin
         input_valid = 1'b1;
         input_data  = 16'(x_pend[0]);
      end else begin
         input_valid = 1'b0;
         input_data  = 16'($urandom);
      end
      if (hold_cnt > 0 && ov0 && out_seen == hold_at) begin
         output_ready = 1'b0;
         hold_cnt--;
      end else begin
         output_ready = ($urandom_range(99) >= out_gap);
      end
      if (prev_stall) begin
         chk("stall_valid", ov0, 1);
         chk("stall_data", sd(od0), prev_data);
      end
      if (lat_armed && ov0 && !prev_valid) begin
         chk("latency", cyc - acc_edge, N + 3);
         lat_armed = 0;
      end
      in_f  = input_valid && ir0;
      out_f = ov0 && output_ready;
      if (out_f) begin
         chk("out_expected", exp0.size() > 0, 1);
         if (exp0.size() > 0) begin
            chk("y_relu0", sd(od0), exp0.pop_front());
            chk("valid_relu1", ov1, 1);
            chk("y_relu1", sd(od1), exp1.pop_front());
         end
         obs0.push_back(sd(od0));
         obs1.push_back(sd(od1));
         out_seen++;
      end
      if (in_f) begin
         xv[xcnt] = x_pend.pop_front();
         xcnt++;
         if (xcnt == N) begin
            for (int i = 0; i < M; i++) begin
               exp0.push_back(ref_y(i, 1'b0));
               exp1.push_back(ref_y(i, 1'b1));
            end
            xcnt = 0;
            if (lat_en) begin
               lat_armed = 1;
               acc_edge  = cyc + 1;
            end
         end
      end
      prev_stall = ov0 && !output_ready;
      prev_data  = sd(od0);
      prev_valid = ov0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr(input int a, input int d, input bit apply);
      w_wr_en = 1'b1;
      w_addr  = 6'(a);
      w_data  = 16'(d);
      cycle();
      w_wr_en = 1'b0;
      if (apply) wm[a] = d;
   endtask

   task automatic load_w(input int mode, input int val);
      int d;
      for (int a = 0; a < M*N; a++) begin
         case (mode)
            0: d = (a / N == a % N) ? 1 : 0;
            1: d = val;
            2: d = a / N + 1;
            3: d = int'($signed(16'($urandom)));
            default: d = int'($urandom_range(600)) - 300;
         endcase
         wr(a, d, 1'b1);
      end
   endtask

   task automatic run_until_idle(input int bound);
      int n = 0;
      while ((x_pend.size() > 0 || exp0.size() > 0 || xcnt != 0) && n < bound) begin
         cycle();
         n++;
      end
      chk("drain_in_time", (x_pend.size() == 0 && exp0.size() == 0), 1);
      chk("idle_busy", busy0, 0);
      chk("idle_input_ready", ir0, 1);
   endtask

   initial begin
      reset = 1'b1; input_valid = 1'b0; output_ready = 1'b0; w_wr_en = 1'b0;
      input_data = 16'd0; w_data = 16'd0; w_addr = 6'd0;
      tbl[0].wmode = 0; tbl[0].wval = 0;      tbl[0].hold = 0;
      tbl[0].x = '{1, 2, 3, 4, 5, 6};
      tbl[0].y0 = '{1, 2, 3, 4, 5, 6};         tbl[0].y1 = '{1, 2, 3, 4, 5, 6};
      tbl[1].wmode = 1; tbl[1].wval = 32767;  tbl[1].hold = 0;
      tbl[1].x = '{32767, 32767, 32767, 32767, 32767, 32767};
      tbl[1].y0 = '{32767, 32767, 32767, 32767, 32767, 32767};
      tbl[1].y1 = '{32767, 32767, 32767, 32767, 32767, 32767};
      tbl[2].wmode = 1; tbl[2].wval = -32768; tbl[2].hold = 0;
      tbl[2].x = '{32767, 32767, 32767, 32767, 32767, 32767};
      tbl[2].y0 = '{-32768, -32768, -32768, -32768, -32768, -32768};
      tbl[2].y1 = '{0, 0, 0, 0, 0, 0};
      tbl[3].wmode = 0; tbl[3].wval = 0;      tbl[3].hold = 0;
      tbl[3].x = '{-1, -2, 3, -4, 5, -6};
      tbl[3].y0 = '{-1, -2, 3, -4, 5, -6};     tbl[3].y1 = '{0, 0, 3, 0, 5, 0};
      tbl[4].wmode = 2; tbl[4].wval = 0;      tbl[4].hold = 1;
      tbl[4].x = '{1, 1, 1, 1, 1, 1};
      tbl[4].y0 = '{6, 12, 18, 24, 30, 36};    tbl[4].y1 = '{6, 12, 18, 24, 30, 36};

      // Reset values, then input_ready rises only after the first clock.
      #2 reset = 1'b0;
      #21;
      chk("rst_output_valid", ov0, 0);
      chk("rst_output_data", sd(od0), 0);
      chk("rst_busy", busy0, 0);
      chk("rst_input_ready", ir0, 0);
      reset = 1'b1;
      #1 chk("input_ready_before_clk", ir0, 0);
      @(posedge clk);
      #1;
      chk("input_ready_after_clk", ir0, 1);

      // Directed table records.
      lat_en = 1;
      foreach (tbl[r]) begin
         load_w(tbl[r].wmode, tbl[r].wval);
         obs0.delete(); obs1.delete();
         if (tbl[r].hold) begin
            hold_at  = out_seen + 1;
            hold_cnt = 5;
         end
         for (int j = 0; j < N; j++) x_pend.push_back(tbl[r].x[j]);
         run_until_idle(400);
         chk("tbl_count", obs0.size(), M);
         for (int i = 0; i < M && i < obs0.size(); i++) begin
            chk($sformatf("tbl%0d_y0[%0d]", r, i), obs0[i], tbl[r].y0[i]);
            chk($sformatf("tbl%0d_y1[%0d]", r, i), obs1[i], tbl[r].y1[i]);
         end
      end
      lat_en = 0;

      // Reset in DRAIN after y[2] has transferred; weights must survive.
      obs0.delete(); obs1.delete();
      for (int j = 0; j < N; j++) x_pend.push_back(j + 2);
      for (int n = 0; n < 400 && obs0.size() < 3; n++) cycle();
      chk("pre_reset_outputs", obs0.size(), 3);
      reset = 1'b0;
      #1;
      chk("midrst_output_valid", ov0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_input_ready", ir0, 0);
      exp0.delete(); exp1.delete(); x_pend.delete();
      xcnt = 0; prev_stall = 0; prev_valid = 0;
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      chk("post_rst_input_ready", ir0, 1);
      obs0.delete(); obs1.delete();
      for (int j = 0; j < N; j++) x_pend.push_back(1);
      run_until_idle(400);
      chk("post_rst_y5", obs0.size() == M ? obs0[M-1] : -1, 36);

      // Weight write while busy is ignored; in LOAD it takes effect.
      load_w(0, 0);
      obs0.delete(); obs1.delete();
      for (int j = 0; j < N; j++) x_pend.push_back(j + 1);
      for (int n = 0; n < 50 && x_pend.size() > 0; n++) cycle();
      chk("busy_in_compute", busy0, 1);
      wr(0, 100, 1'b0);
      run_until_idle(400);
      chk("busy_write_ignored", obs0.size() > 0 ? obs0[0] : -1, 1);
      obs0.delete(); obs1.delete();
      for (int j = 0; j < N; j++) x_pend.push_back(j + 1);
      cycle();
      cycle();
      wr(0, 100, 1'b1);
      run_until_idle(400);
      chk("load_write_applied", obs0.size() > 0 ? obs0[0] : -1, 100);

      // Randomized back-to-back vectors with handshake gaps.
      in_gap  = 25;
      out_gap = 25;
      for (int b = 0; b < 20; b++) begin
         load_w((b % 2 == 0) ? 4 : 3, 0);
         for (int v = 0; v < 50; v++) begin
            for (int j = 0; j < N; j++) begin
               if ($urandom_range(3) == 0) x_pend.push_back(int'($signed(16'($urandom))));
               else x_pend.push_back(int'($urandom_range(400)) - 200);
            end
         end
         run_until_idle(20000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fc_mvm_par.md
Name: fc_mvm_par

Overview:
- Parametrised fully-connected layer: computes y = f(W·x) for an M×N signed weight matrix and an N-element input vector, streaming x in and y out over valid/ready handshakes.
- Successor to the fixed-size ROM-based fc blocks:
  - weights are run-time loadable through a write port;
  - P rows are computed in parallel;
  - results saturate to T bits;
  - optional ReLU.
- Sits between the previous layer's output stream and the next layer's input stream.

Parameters:
- M, 6, output vector length (rows of W); M % P == 0.
- N, 6, input vector length (columns of W); N >= 2.
- T, 16, signed data and weight width.
- P, 2, parallel MAC lanes (rows computed concurrently); 1 <= P <= M.
- RELU, 0, 1 = clamp negative results to 0 after saturation.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_valid  in  1  input_data valid.
- input_ready  out  1  block accepts an x element this cycle.
- input_data  in  T  signed x element; x[0] first.
- output_valid  out  1  output_data valid.
- output_ready  in  1  downstream accepts y element.
- output_data  out  T  signed y element; y[0] first.
- w_wr_en  in  1  weight write strobe.
- w_addr  in  clog2(M*N)  weight address, row-major: W[i][j] at i*N+j.
- w_data  in  T  signed weight value.
- busy  out  1  high in COMPUTE/DRAIN; weight writes ignored while high.

Behaviour:
- Reset (reset=0, async): state=LOAD, input_ready=0 until first clk after release then 1, output_valid=0, output_data=0, busy=0, element/row counters=0. Weight memory is NOT cleared; it retains its contents across reset. Reset mid-COMPUTE/DRAIN aborts the vector; the partial vector is discarded.
- Handshake: a transfer occurs on a rising edge with valid&&ready. output_data and output_valid must hold stable while output_valid=1 && output_ready=0. input_ready does not depend combinationally on input_valid.
- States:
  - LOAD: input_ready=1. Each transfer writes x[cnt]; on the N-th transfer go to COMPUTE, row group g=0.
  - COMPUTE: input_ready=0, busy=1.
    - Each cycle issues column k (0..N-1) to all P lanes. Lane p uses row g*P+p.
    - Weight/x memory reads are synchronous (1 cycle); the product is registered (1 cycle); the accumulate takes 1 cycle.
    - The accumulator clears at k=0 of each group.
    - After the last accumulate, results go to DRAIN.
  - DRAIN: busy=1.
    - Presents lanes 0..P-1 in order, one per output transfer.
    - After lane P-1 transfers: if g<M/P-1, g++ and return to COMPUTE; else go to LOAD.
- Latency: output_valid for y[0] rises exactly N+3 cycles after the edge accepting x[N-1]. Each subsequent group starts COMPUTE the cycle after the previous group's last output transfer.
- Arithmetic:
  - Product is the full 2T-bit signed product.
  - Accumulator is 2T+clog2(N) bits signed; no wrap is possible.
  - Final value saturates to [-2^(T-1), 2^(T-1)-1].
  - If RELU=1, negative saturated values become 0.
- Weight writes:
  - Accepted in LOAD (including mid-vector).
  - Ignored when busy=1.
  - w_addr >= M*N is ignored.
  - A write and an input transfer in the same cycle are both performed.
- Output order is y[0..M-1] strictly ascending. No output is dropped or duplicated under any output_ready pattern.

Test Plan:
- Load identity W (M=N=6, P=2). Stream x=[1,2,3,4,5,6] with input_valid held 1 and output_ready=1 -> y=[1,2,3,4,5,6]; y[0] valid exactly 9 cycles after x[5] accepted.
- Saturation: all W=32767, x all 32767 -> every y=32767. All W=-32768, x all 32767 -> every y=-32768 (RELU=0), and every y=0 with RELU=1.
- Backpressure: W row i = all (i+1), x all 1. Deassert output_ready for 5 cycles while y[1] is presented -> y[1]=12 held stable; full sequence [6,12,18,24,30,36] with no loss.
- Busy write: during COMPUTE write W[0][0]=100 -> ignored, y unchanged. Repeat the same write during LOAD -> next vector's y[0] reflects 100.
- Reset mid-DRAIN after y[2]: output_valid=0 immediately, state=LOAD. A fresh x yields correct y from the retained weights.
- Back-to-back vectors with random input_valid/output_ready gaps (1000 vectors, random W/x) -> outputs match the saturating reference model bit-exactly.
